// File: rtl/wb_master_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of the i2cmb register port.
// Define WB_ARB_WATCHDOG_EN to compile in the hung-cycle watchdog and ABORT path.
module wb_master_arbiter #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;
    logic   req0;
    logic   req1;
    logic   pick0;
    logic   pick1;
    logic   owner_cyc;
    logic   timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // On a tie the requester that did not own the bus last time wins.
    assign pick0 = req0 & (~req1 | last_gnt);
    assign pick1 = req1 & ~pick0;

    assign owner_cyc = last_gnt ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] wd_cnt;
    logic          granted;

    assign granted = (state == GNT0) || (state == GNT1);
    assign timeout = granted && (wd_cnt == TMO);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_cnt <= '0;
        end else if (!granted || s_ack_i || (state_nxt != state)) begin
            wd_cnt <= '0;
        end else if (s_stb_o) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    // Without the watchdog the timeout parameter has no effect.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state_nxt == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                unique case (1'b1)
                    pick0:   state_nxt = GNT0;
                    pick1:   state_nxt = GNT1;
                    default: state_nxt = IDLE;
                endcase
            end
            GNT0: begin
                if (timeout) begin
                    state_nxt = ABORT;
                end else if (!m0_cyc_i) begin
                    state_nxt = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (timeout) begin
                    state_nxt = ABORT;
                end else if (!m1_cyc_i) begin
                    state_nxt = req0 ? GNT0 : IDLE;
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux and requester return paths; the loser sees zeros.
    always_comb begin
        gnt_o    = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                gnt_o    = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                gnt_o    = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_err_o = timeout & (state == GNT0);
    assign m1_err_o = timeout & (state == GNT1);

endmodule
